// File: rtl/led_seq_pkg.sv
// Shared constants, FSM encoding and small helpers for the LED walker sequencer.
package led_seq_pkg;

  localparam int N_LED = 16;
  localparam int POS_W = $clog2(N_LED);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_LEFT   = 3'd2,
    S_RIGHT  = 3'd3,
    S_BOUNCE = 3'd4
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_LEFT:   mode_to_state = S_LEFT;
      MODE_RIGHT:  mode_to_state = S_RIGHT;
      MODE_BOUNCE: mode_to_state = S_BOUNCE;
      default:     mode_to_state = S_HOLD;
    endcase
  endfunction

  function automatic logic [N_LED-1:0] onehot(input logic [POS_W-1:0] p);
    onehot = '0;
    onehot[p] = 1'b1;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_prescaler.sv
// Step-rate prescaler: counts 0..div-1 and pulses tick on the last count; div==0 acts as 1.
module tick_prescaler #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;

  always_comb div_eff = (div == '0) ? DIV_W'(1) : div;

  assign tick = (cnt == div_eff - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// One-hot LED walker: config handshake, mode FSM and registered pos/dir/led/wrap outputs.
// Handshake: a transfer happens on a cycle with cfg_valid && cfg_ready; cfg_ready drops for the one cycle after each transfer.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DIV_W   = 27,
  parameter int DIV_RST = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [N_LED-1:0] led,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             wrap,
  output state_t           dbg_state
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic             accept;
  logic             tick;
  logic [POS_W-1:0] pos_nx;
  logic             dir_nx;
  logic             wrap_nx;

  assign accept    = cfg_valid && cfg_ready;
  assign dbg_state = state;

  tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .div   (div_q),
    .tick  (tick)
  );

  // Candidate step for the current state; only committed on a tick with no accept.
  always_comb begin
    pos_nx  = pos;
    dir_nx  = dir;
    wrap_nx = 1'b0;
    case (state)
      S_LEFT: begin
        pos_nx  = pos + POS_W'(1);
        dir_nx  = 1'b1;
        wrap_nx = (pos == POS_MAX);
      end
      S_RIGHT: begin
        pos_nx  = pos - POS_W'(1);
        dir_nx  = 1'b0;
        wrap_nx = (pos == '0);
      end
      S_BOUNCE: begin
        if (dir) begin
          if (pos == POS_MAX) begin
            pos_nx  = pos - POS_W'(1);
            dir_nx  = 1'b0;
            wrap_nx = 1'b1;
          end else begin
            pos_nx = pos + POS_W'(1);
          end
        end else begin
          if (pos == '0) begin
            pos_nx  = POS_W'(1);
            dir_nx  = 1'b1;
            wrap_nx = 1'b1;
          end else begin
            pos_nx = pos - POS_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      div_q     <= DIV_W'(DIV_RST);
      pos       <= '0;
      dir       <= 1'b1;
      led       <= '0;
      wrap      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      wrap      <= 1'b0;
      cfg_ready <= !accept;
      if (accept) begin
        // An accept swallows any coincident tick; pos is kept and shown right away.
        state <= mode_to_state(cfg_mode);
        div_q <= cfg_div;
        led   <= onehot(pos);
        if (cfg_mode == MODE_BOUNCE) begin
          if (pos == POS_MAX) dir <= 1'b0;
          else if (pos == '0) dir <= 1'b1;
        end
      end else if (tick && state != S_IDLE) begin
        pos  <= pos_nx;
        dir  <= dir_nx;
        wrap <= wrap_nx;
        led  <= onehot(pos_nx);
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed and randomized checks of led_seq_ctrl against a cycle-level reference model.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  localparam int DIV_W   = 27;
  localparam int DIV_RST = 12_500_000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_mode = 2'b00;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [15:0]      led;
  logic [3:0]       pos;
  logic             dir;
  logic             wrap;
  state_t           dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: m_mode = -1 means "not yet configured".
  int m_mode = -1;
  int m_pos = 0;
  int m_dir = 1;
  int m_wrap = 0;
  int m_ready = 1;
  longint m_div = DIV_RST;
  longint m_cnt = 0;

  led_seq_ctrl #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .led       (led),
    .pos       (pos),
    .dir       (dir),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int step;
    int np;
    bit tick;
    if (!reset) begin
      m_mode = -1; m_pos = 0; m_dir = 1; m_wrap = 0; m_ready = 1;
      m_div = DIV_RST; m_cnt = 0;
      return;
    end
    tick = (m_cnt == m_div - 1);
    m_wrap = 0;
    if (cfg_valid && m_ready) begin
      m_mode  = int'(cfg_mode);
      m_div   = (cfg_div == 0) ? 1 : longint'(cfg_div);
      m_cnt   = 0;
      m_ready = 0;
      if (m_mode == 3 && m_pos == 15) m_dir = 0;
      if (m_mode == 3 && m_pos == 0)  m_dir = 1;
      return;
    end
    m_ready = 1;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (!tick) return;
    case (m_mode)
      1: begin
        m_wrap = (m_pos == 15); m_pos = (m_pos + 1) % 16; m_dir = 1;
      end
      2: begin
        m_wrap = (m_pos == 0); m_pos = (m_pos + 15) % 16; m_dir = 0;
      end
      3: begin
        step = m_dir ? 1 : -1;
        np = m_pos + step;
        if (np < 0 || np > 15) begin
          np = m_pos - step; m_dir = 1 - m_dir; m_wrap = 1;
        end
        m_pos = np;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("led", 32'(led), (m_mode < 0) ? 32'h0 : (32'h1 << m_pos));
    chk("pos", 32'(pos), 32'(m_pos));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("idle", 32'(dbg_state == S_IDLE), 32'(m_mode < 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_cfg(input logic [1:0] mode, input int div);
    if (!m_ready) cycle();
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_div   = DIV_W'(div);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pos(input int target, input string tag);
    int budget;
    budget = 400;
    while (m_pos != target && budget > 0) begin
      cycle();
      budget--;
    end
    chk({tag, "_reached"}, 32'(budget > 0), 32'h1);
  endtask

  initial begin
    int saved_pos;
    int budget;

    // Reset held 3 cycles, then idle for 50 cycles.
    reset = 1'b0;
    run(3);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_pos", 32'(pos), 32'h0);
    reset = 1'b1;
    run(50);
    chk("idle_led", 32'(led), 32'h0);

    // LEFT at div=4: 16 steps ends 15->0 with a wrap pulse.
    send_cfg(MODE_LEFT, 4);
    chk("left_first_led", 32'(led), 32'h0001);
    run(4);
    chk("left_step1_led", 32'(led), 32'h0002);
    run(60);
    chk("left_wrap_pos", 32'(pos), 32'h0);
    chk("left_wrap_pulse", 32'(wrap), 32'h1);
    run(1);
    chk("left_wrap_gone", 32'(wrap), 32'h0);

    // RIGHT at div=1 from pos 0.
    send_cfg(MODE_RIGHT, 1);
    run(1);
    chk("right_led8000", 32'(led), 32'h8000);
    chk("right_wrap", 32'(wrap), 32'h1);
    run(15);
    chk("right_back0", 32'(pos), 32'h0);

    // BOUNCE at div=2 through a full ping-pong.
    send_cfg(MODE_BOUNCE, 2);
    run(70);

    // Accept coincident with a tick, plus a second valid while cfg_ready is low.
    send_cfg(MODE_LEFT, 4);
    budget = 20;
    while (m_cnt != m_div - 1 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("tick_align", 32'(budget > 0), 32'h1);
    saved_pos = m_pos;
    cfg_valid = 1'b1;
    cfg_mode  = MODE_LEFT;
    cfg_div   = DIV_W'(3);
    cycle();
    chk("acc_tick_nostep", 32'(pos), 32'(saved_pos));
    cfg_mode  = MODE_RIGHT;
    cycle();
    cfg_valid = 1'b0;
    chk("b2b_ignored_dir", 32'(pos), 32'(saved_pos));
    run(2);
    chk("step_after_div", 32'(pos), 32'((saved_pos + 1) % 16));

    // LEFT to pos 9, freeze in HOLD, then reset mid-run with valid asserted.
    wait_pos(9, "hold9");
    send_cfg(MODE_HOLD, 1);
    run(20);
    chk("hold_led", 32'(led), 32'h0200);
    chk("hold_pos", 32'(pos), 32'h9);
    cfg_valid = 1'b1;
    cfg_mode  = MODE_LEFT;
    reset     = 1'b0;
    cycle();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_idle", 32'(dbg_state == S_IDLE), 32'h1);
    run(5);

    // Randomized traffic including div==0 and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) != 0);
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_div   = DIV_W'($urandom_range(0, 5));
      cycle();
    end
    reset     = 1'b1;
    cfg_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
